uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter with an internal byte FIFO; the transmit-side counterpart of the UART receive path.
- Upstream logic (RX echo buffer, status reporters) pushes bytes through a valid/ready port; the block serialises them on uart_tx.
- Queued bytes go out back-to-back with no idle gap between frames.
- Runs at the same bit timing as the receiver.

Parameters:
- DELAY_FRAMES, 234, sys_clk cycles per UART bit (27 MHz / 115200). Legal values are >= 2.
- FIFO_DEPTH_LOG2, 4, log2 of FIFO depth. Default gives 16 entries.

Ports:
- sys_clk  input  1  clock; all logic on the rising edge
- sys_rst_n  input  1  reset, synchronous, active-low
- wr_data  input  8  byte to enqueue
- wr_valid  input  1  wr_data is valid this cycle
- wr_ready  output  1  FIFO can accept a byte
- uart_tx  output  1  serial line; idles high
- busy  output  1  frame in progress or FIFO non-empty
- level  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Reset (sys_rst_n==0 at a rising edge):
  - Next state: uart_tx=1, busy=0, level=0, FSM=IDLE, read/write pointers=0, bit counter=0.
  - wr_ready is driven 0 whenever sys_rst_n==0; pushes in that cycle are ignored.
- Reset mid-frame: the partial frame is abandoned, uart_tx returns high on that edge, and FIFO contents are discarded.
- wr_ready = (level != 2**FIFO_DEPTH_LOG2), taken from registered level.
  - A pop in the same cycle does not raise wr_ready while full.
- Push: on an edge with wr_valid && wr_ready, wr_data is written at wr_ptr; wr_ptr increments modulo depth.
- Pop: occurs only on the FSM load edge (below); rd_ptr increments modulo depth.
- Push and pop on the same edge: level unchanged and both pointers advance.
- The FIFO is not fall-through. A byte pushed into an empty FIFO is popped no earlier than the following edge.
- FSM states: IDLE, START, DATA, STOP. A bit counter runs 0..DELAY_FRAMES-1, and a 3-bit index selects the data bit.
  - IDLE: uart_tx=1. If level!=0: pop into shift register, uart_tx<=0, counter<=0, go START.
  - START: hold uart_tx=0. When counter==DELAY_FRAMES-1: uart_tx<=shift[0], index<=0, counter<=0, go DATA. Otherwise counter++.
  - DATA: hold the current bit, LSB first. At counter==DELAY_FRAMES-1:
    - If index==7: uart_tx<=1, go STOP.
    - Otherwise: index++ and uart_tx<=next bit.
    - In both cases counter<=0.
  - STOP: hold uart_tx=1. At counter==DELAY_FRAMES-1:
    - If level!=0: pop, uart_tx<=0, go START (back-to-back).
    - Otherwise go IDLE.
    - In both cases counter<=0.
- uart_tx is a register; no combinational path from inputs to uart_tx.
- Each bit is held exactly DELAY_FRAMES cycles, so one frame is exactly 10*DELAY_FRAMES cycles.
- Latency: for a byte accepted at edge E into an empty FIFO with FSM in IDLE, uart_tx falls at edge E+2.
  - Edge E+1 makes level visible; edge E+2 is the load edge.
- busy = (FSM != IDLE) || (level != 0), registered-state derived.
- The counter is sized to clog2(DELAY_FRAMES) bits. Comparisons never rely on overflow.

Test Plan:
- DELAY_FRAMES=4; push 0x55 once into idle block -> uart_tx low at accept-edge+2, then bits 1,0,1,0,1,0,1,0 each 4 cycles, high stop 4 cycles; busy falls after stop; total frame 40 cycles.
- Push 0xA3, 0x00, 0xFF on consecutive cycles -> three frames with no idle gap (frames exactly 40 cycles apart); decoded bytes match in order; level peaks at 3 (or 2 if the first pop coincides).
- Hold wr_valid high with incrementing data from 0x00 while uart_tx is busy -> wr_ready drops after level reaches 16; held byte is accepted only after the next pop; all bytes arrive in order without loss or duplication, including across pointer wrap (more than 32 bytes total).
- Full FIFO with a pop on the same edge as a push attempt -> push not accepted that cycle (wr_ready=0), accepted the next cycle, level stays 16.
- Assert sys_rst_n=0 for one cycle midway through DATA of a frame -> uart_tx=1 and level=0 on the next cycle, busy=0, no further transitions; a subsequent push transmits a clean full frame.
- No pushes for 1000 cycles after reset -> uart_tx constant 1, busy=0, wr_ready=1, level=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a valid/ready byte FIFO.
// Queued bytes leave back-to-back; each bit is held DELAY_FRAMES clocks.
module uart_tx_fifo #(
  parameter int unsigned DELAY_FRAMES    = 234,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [7:0]                 wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic                       uart_tx,
  output logic                       busy,
  output logic [FIFO_DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned LVL_W = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q;
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             nonempty_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic push;
  logic pop;
  logic bit_end;

  assign wr_ready = sys_rst_n && (level_q != LVL_FULL);
  assign push     = wr_valid && wr_ready;
  assign bit_end  = (cnt_q == CNT_LAST);
  // IDLE waits for a level seen on the previous cycle, giving the push-to-start latency of two edges
  assign pop      = (level_q != '0) &&
                    (((state_q == IDLE) && nonempty_q) || ((state_q == STOP) && bit_end));

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop && !push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      nonempty_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q    <= level_d;
      nonempty_q <= (level_q != '0);
    end
  end

  // Frame sequencer: start bit, 8 data bits LSB first, stop bit
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            tx_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              idx_q   <= idx_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx = tx_q;
  assign level   = level_q;
  assign busy    = (state_q != IDLE) || (level_q != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed corner sequences and random traffic,
// all checked every cycle against a frame-schedule model of the transmitter.
module tb_uart_tx_fifo;

  localparam int D     = 4;
  localparam int LOG2  = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * D;

  logic           sys_clk;
  logic           sys_rst_n;
  logic [7:0]     wr_data;
  logic           wr_valid;
  logic           wr_ready;
  logic           uart_tx;
  logic           busy;
  logic [LOG2:0]  level;

  uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH_LOG2(LOG2)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .level     (level)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: every accepted byte with the edge at which its start bit begins
  int         m_start[$];
  logic [7:0] m_data[$];
  int         last_start;
  bit         has_last;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int m_level(input int c);
    int n;
    n = 0;
    for (int k = 0; k < m_start.size(); k++)
      if (m_start[k] > c) n++;
    return n;
  endfunction

  function automatic bit m_active(input int c);
    bit r;
    r = 1'b0;
    for (int k = 0; k < m_start.size(); k++)
      if (c >= m_start[k] && c < m_start[k] + FRAME) r = 1'b1;
    return r;
  endfunction

  function automatic logic m_tx(input int c);
    logic       r;
    logic [7:0] byte_v;
    int         b;
    r = 1'b1;
    for (int k = 0; k < m_start.size(); k++) begin
      if (c >= m_start[k] && c < m_start[k] + FRAME) begin
        b      = (c - m_start[k]) / D;
        byte_v = m_data[k];
        if (b == 0)      r = 1'b0;
        else if (b <= 8) r = byte_v[b-1];
        else             r = 1'b1;
      end
    end
    return r;
  endfunction

  // One clock: drive inputs, check wr_ready before the edge, update model, check outputs after
  task automatic step(input logic rst_v, input logic vld_v, input logic [7:0] dat_v,
                      output logic acc, output logic rdy_seen);
    logic exp_rdy;
    int   t_end;
    sys_rst_n = rst_v;
    wr_valid  = vld_v;
    wr_data   = dat_v;
    #1;
    exp_rdy  = rst_v && (m_level(cyc) != DEPTH);
    rdy_seen = wr_ready;
    chk("wr_ready", int'(wr_ready), int'(exp_rdy));
    @(posedge sys_clk);
    cyc++;
    acc = vld_v && exp_rdy;
    if (!rst_v) begin
      m_start.delete();
      m_data.delete();
      has_last = 1'b0;
    end else if (acc) begin
      t_end = has_last ? last_start + FRAME : -1;
      last_start = (cyc < t_end) ? t_end : cyc + 2;
      has_last   = 1'b1;
      m_start.push_back(last_start);
      m_data.push_back(dat_v);
    end
    while (m_start.size() > 0 && m_start[0] + FRAME < cyc) begin
      void'(m_start.pop_front());
      void'(m_data.pop_front());
    end
    @(negedge sys_clk);
    chk("uart_tx", int'(uart_tx), int'(m_tx(cyc)));
    chk("level", int'(level), m_level(cyc));
    chk("busy", int'(busy), int'(m_active(cyc) || (m_level(cyc) != 0)));
  endtask

  task automatic idle(input int n);
    logic a, r;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, a, r);
  endtask

  task automatic drain(input int max_cycles);
    logic a, r;
    int   g;
    g = 0;
    while ((busy || m_level(cyc) != 0 || m_active(cyc)) && g < max_cycles) begin
      step(1'b1, 1'b0, 8'h00, a, r);
      g++;
    end
    chk("drain_timeout", int'(busy), 0);
  endtask

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    int         exp_level;
    logic       exp_busy;
    logic       exp_tx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic acc, rdy;
    int   e_acc, fall_at, busy_low_at, peak, acc_cnt, stalls, guard, trans;
    logic [7:0] d;
    logic prev_tx;

    sys_rst_n = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
    has_last  = 1'b0;
    last_start = 0;

    // Reset, push 0x55 into idle block (edge E = row 2), start bit at E+2, reset mid-frame
    vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h55, 1'b1, 1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h77, 1'b0, 0, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1};

    @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].rst_n, vecs[i].valid, vecs[i].data, acc, rdy);
      chk("vec_ready", int'(rdy), int'(vecs[i].exp_ready));
      chk("vec_level", int'(level), vecs[i].exp_level);
      chk("vec_busy", int'(busy), int'(vecs[i].exp_busy));
      chk("vec_tx", int'(uart_tx), int'(vecs[i].exp_tx));
    end

    // Single 0x55 frame: start at E+2, busy clears at E+42
    step(1'b1, 1'b1, 8'h55, acc, rdy);
    e_acc = cyc;
    fall_at = -1;
    busy_low_at = -1;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b0, 8'h00, acc, rdy);
      if (fall_at < 0 && uart_tx == 1'b0) fall_at = cyc;
      if (fall_at >= 0 && busy_low_at < 0 && !busy) busy_low_at = cyc;
    end
    chk("start_latency", fall_at - e_acc, 2);
    chk("frame_busy_len", busy_low_at - fall_at, FRAME);

    // Three consecutive pushes: frames back-to-back, first pop coincides with third push
    peak = 0;
    step(1'b1, 1'b1, 8'hA3, acc, rdy);
    if (int'(level) > peak) peak = int'(level);
    step(1'b1, 1'b1, 8'h00, acc, rdy);
    if (int'(level) > peak) peak = int'(level);
    step(1'b1, 1'b1, 8'hFF, acc, rdy);
    if (int'(level) > peak) peak = int'(level);
    chk("burst_peak_level", peak, 2);
    drain(200);

    // Saturate the FIFO with incrementing data across pointer wrap
    d = 8'h00; acc_cnt = 0; stalls = 0; peak = 0; guard = 0;
    while (acc_cnt < 40 && guard < 4000) begin
      step(1'b1, 1'b1, d, acc, rdy);
      if (acc) begin d++; acc_cnt++; end
      else stalls++;
      if (int'(level) > peak) peak = int'(level);
      guard++;
    end
    chk("fill_accepted", acc_cnt, 40);
    chk("fill_peak_level", peak, DEPTH);
    chk("fill_stalled", int'(stalls > 0), 1);
    drain(2500);

    // Reset in the middle of DATA, then a clean frame
    step(1'b1, 1'b1, 8'hC3, acc, rdy);
    idle(10);
    step(1'b0, 1'b0, 8'h00, acc, rdy);
    chk("midreset_tx", int'(uart_tx), 1);
    chk("midreset_level", int'(level), 0);
    chk("midreset_busy", int'(busy), 0);
    trans = 0;
    prev_tx = uart_tx;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 8'h00, acc, rdy);
      if (uart_tx != prev_tx) trans++;
      prev_tx = uart_tx;
    end
    chk("midreset_quiet", trans, 0);
    step(1'b1, 1'b1, 8'h3C, acc, rdy);
    drain(200);

    // Long idle after reset
    step(1'b0, 1'b0, 8'h00, acc, rdy);
    trans = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b0, 8'h00, acc, rdy);
      if (uart_tx != 1'b1 || busy || !wr_ready || level != '0) trans++;
    end
    chk("long_idle_quiet", trans, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic r, v;
      r = ($urandom_range(0, 599) != 0);
      v = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
      step(r, v, 8'($urandom), acc, rdy);
    end
    drain(2500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout @cycle %0d: got running expected finished", cyc);
    $fatal(1);
  end

endmodule
